// File: rtl/lfsr_encryptor.sv
// LFSR stream encryptor: reads a configuration and an ASCII message from data memory, then
// writes 64 bytes of pre-padded, LFSR-whitened, parity-tagged ciphertext at OUT_BASE.
module lfsr_encryptor #(
  parameter int unsigned OUT_BASE = 64,
  parameter int unsigned MSG_MAX  = 52
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCfg  = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [7:0] AddrPre  = 8'd61;
  localparam logic [7:0] AddrTaps = 8'd62;
  localparam logic [7:0] AddrInit = 8'd63;
  localparam logic [7:0] OutBase  = 8'(OUT_BASE);
  localparam logic [7:0] MsgMax   = 8'(MSG_MAX);
  localparam logic [3:0] PreMin   = 4'd10;
  localparam logic [5:0] LastByte = 6'd63;

  logic [2:0] state_q, state_d;
  logic       armed_q, armed_d;
  logic [1:0] cfg_cnt_q, cfg_cnt_d;
  logic [5:0] byte_q, byte_d;
  logic [3:0] pre_q, pre_d;
  logic [6:0] taps_q, taps_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [7:0] msg_idx;
  logic       in_range;
  logic [7:0] padded;
  logic [6:0] enc7;
  logic [7:0] enc;
  logic       feedback;

  // Message index for the current byte; bytes before pre_length or past MSG_MAX are padding.
  always_comb begin
    msg_idx  = {2'b00, byte_q} - {4'b0000, pre_q};
    in_range = ({2'b00, byte_q} >= {4'b0000, pre_q}) && (msg_idx < MsgMax);
    padded   = in_range ? (rd_data - 8'h20) : 8'h00;
    enc7     = padded[6:0] ^ lfsr_q;
    enc      = {^enc7, enc7};
    feedback = ^(lfsr_q & taps_q);
  end

  always_comb begin
    Ack     = (state_q == StDone);
    wr_en   = (state_q == StWr);
    wr_addr = OutBase + {2'b00, byte_q};
    // Read data only arrives in the WR cycle; hold the last written byte elsewhere.
    wr_data = wr_en ? enc : wr_data_q;
    rd_addr = 8'h00;
    case (state_q)
      StCfg: begin
        case (cfg_cnt_q)
          2'd0:    rd_addr = AddrPre;
          2'd1:    rd_addr = AddrTaps;
          2'd2:    rd_addr = AddrInit;
          default: rd_addr = 8'h00;
        endcase
      end
      StRd:    rd_addr = in_range ? msg_idx : 8'h00;
      default: rd_addr = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cfg_cnt_d = cfg_cnt_q;
    byte_d    = byte_q;
    pre_d     = pre_q;
    taps_d    = taps_q;
    lfsr_d    = lfsr_q;
    wr_data_d = wr_data;
    case (state_q)
      StIdle: begin
        if (Start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d   = 1'b0;
          state_d   = StCfg;
          cfg_cnt_d = 2'd0;
          byte_d    = 6'd0;
        end
      end
      StCfg: begin
        cfg_cnt_d = cfg_cnt_q + 2'd1;
        // Each capture lands one cycle after its address was presented.
        case (cfg_cnt_q)
          2'd1: pre_d = (rd_data[3:0] < PreMin) ? PreMin : rd_data[3:0];
          2'd2: taps_d = rd_data[6:0];
          2'd3: begin
            lfsr_d  = (rd_data[6:0] == 7'h00) ? 7'h01 : rd_data[6:0];
            state_d = StRd;
          end
          default: ;
        endcase
      end
      StRd: state_d = StWr;
      StWr: begin
        lfsr_d = {lfsr_q[5:0], feedback};
        if (byte_q == LastByte) begin
          state_d = StDone;
        end else begin
          byte_d  = byte_q + 6'd1;
          state_d = StRd;
        end
      end
      StDone: begin
        if (Start) begin
          armed_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      cfg_cnt_q <= 2'd0;
      byte_q    <= 6'd0;
      pre_q     <= PreMin;
      taps_q    <= 7'h00;
      lfsr_q    <= 7'h00;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      cfg_cnt_q <= cfg_cnt_d;
      byte_q    <= byte_d;
      pre_q     <= pre_d;
      taps_q    <= taps_d;
      lfsr_q    <= lfsr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
